// File: rtl/serial_add_sched_pkg.sv
// Shared types and helpers for the bit-serial adder scheduler.
package serial_add_sched_pkg;

  // Number of requesters sharing the bit cell.
  localparam int NUM_REQ = 2;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Requester id; one bit for two requesters.
  typedef logic [$clog2(NUM_REQ)-1:0] id_t;

  // Bit-counter width: clog2(width) but never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_sched_full_adder.sv
// One-bit full adder: the single arithmetic cell shared by all requesters.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sched.sv
// Bit-serial adder scheduler: two round-robin requesters share one full_adder,
// operands are shifted through it LSB first, one bit per clock.
module serial_add_sched
  import serial_add_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             busy,
  output logic             gnt_id,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;
  id_t              gnt_q, last_q, win;
  logic             any_req, fa_s, fa_co;

  // Shared bit cell: always looks at the current LSBs and the running carry.
  full_adder u_cell (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // Round-robin pick: a lone request wins; on a tie the one not served last wins.
  assign any_req = req0 | req1;
  assign win     = (req0 && req1) ? id_t'(~last_q) : id_t'(req1);

  // State register.
  // NOTE: every clocked process uses non-blocking (<=) so all registers update
  // from pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps this purely combinational;
  // any path that skipped state_nxt would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = RUN;
      RUN:     if (cnt_q == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: latch operands at grant, shift one bit per RUN cycle.
  // NOTE: the operand and result shift registers are plain flops, so they get
  // an async reset like everything else and sum reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      last_q  <= '1;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            a_q     <= win ? a1 : a0;
            b_q     <= win ? b1 : b0;
            carry_q <= win ? cin1 : cin0;
            gnt_q   <= win;
            last_q  <= win;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          carry_q <= fa_co;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) cout_q <= fa_co;
        end
        default: ;
      endcase
    end
  end

  assign sum    = res_q;
  assign cout   = cout_q;
  assign gnt_id = gnt_q;

endmodule
